pipe_addsub: RTL

//   Parametrised, pipelined adder/subtractor for the datapath ALU.

---
 rtl/pipe_addsub_pkg.sv | 14 +
 rtl/pipe_addsub_if.sv | 38 +++
 rtl/pipe_addsub_chunk_stage.sv | 45 ++++
 rtl/pipe_addsub.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// The optional flag outputs are enabled by PIPE_ADDSUB_FLAGS_EN.
package pipe_addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result valid-ready bundle for pipe_addsub.
// The flags signal exists only when PIPE_ADDSUB_FLAGS_EN is defined.
interface pipe_addsub_if #(
    parameter int WIDTH = 32
);
    import pipe_addsub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDSUB_FLAGS_EN
    logic [3:0]       flags;
`endif

    modport master (
        output in_valid, op, a, b, cin, out_ready,
`ifdef PIPE_ADDSUB_FLAGS_EN
        input  flags,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
`ifdef PIPE_ADDSUB_FLAGS_EN
        output flags,
`endif
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/pipe_addsub_chunk_stage.sv
// One pipeline slice: a CHUNK-bit add with registered sum, carry and valid.
// Loads only when en is high so the whole pipe freezes together under back-pressure.
module addsub_chunk_stage #(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [CHUNK-1:0] sum_o,
    output logic             carry_o
);

    logic             valid_d, valid_q;
    logic [CHUNK-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;

    always_comb begin
        valid_d          = valid_i;
        {carry_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
    end

    // NOTE: state is updated with non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: carry chain split into STAGES chunks with skew/deskew registers.
// Define PIPE_ADDSUB_FLAGS_EN to add the registered {N,Z,V,C} flags output.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_addsub_if.slave bus
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic             accept;
    logic             out_valid;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is a + ~b + 1, so the inversion and forced carry happen before stage 0.
    always_comb begin
        b_eff   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
        cin_eff = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
        advance = !out_valid || bus.out_ready;
        accept  = bus.in_valid && advance;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int OPW = (STAGES - k) * CHUNK;

        logic [OPW-1:0]         a_in;
        logic [OPW-1:0]         b_in;
        logic                   carry_in;
        logic                   valid_in;
        logic                   valid_q;
        logic                   carry_q;
        logic [CHUNK-1:0]       chunk_q;
        logic [(k+1)*CHUNK-1:0] sum_acc;
`ifdef PIPE_ADDSUB_FLAGS_EN
        logic [1:0]             msb_in;
        logic [1:0]             msb_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)          msb_q <= '0;
            else if (advance) msb_q <= msb_in;
        end
`endif

        if (k == 0) begin : g_head
            assign a_in     = bus.a;
            assign b_in     = b_eff;
            assign carry_in = cin_eff;
            assign valid_in = accept;
            assign sum_acc  = chunk_q;
`ifdef PIPE_ADDSUB_FLAGS_EN
            assign msb_in   = {bus.a[WIDTH-1], b_eff[WIDTH-1]};
`endif
        end else begin : g_body
            // Upper operand chunks wait here; finished lower sum chunks ride alongside.
            logic [OPW-1:0]     a_d, a_q;
            logic [OPW-1:0]     b_d, b_q;
            logic [k*CHUNK-1:0] lo_d, lo_q;

            always_comb begin
                a_d  = g_stage[k-1].a_in[OPW+CHUNK-1:CHUNK];
                b_d  = g_stage[k-1].b_in[OPW+CHUNK-1:CHUNK];
                lo_d = g_stage[k-1].sum_acc;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    lo_q <= '0;
                end else if (advance) begin
                    a_q  <= a_d;
                    b_q  <= b_d;
                    lo_q <= lo_d;
                end
            end

            assign a_in     = a_q;
            assign b_in     = b_q;
            assign carry_in = g_stage[k-1].carry_q;
            assign valid_in = g_stage[k-1].valid_q;
            assign sum_acc  = {chunk_q, lo_q};
`ifdef PIPE_ADDSUB_FLAGS_EN
            assign msb_in   = g_stage[k-1].msb_q;
`endif
        end

        addsub_chunk_stage #(.CHUNK(CHUNK)) u_chunk (
            .clk     (clk),
            .rst     (rst),
            .en      (advance),
            .valid_i (valid_in),
            .a_i     (a_in[CHUNK-1:0]),
            .b_i     (b_in[CHUNK-1:0]),
            .carry_i (carry_in),
            .valid_o (valid_q),
            .sum_o   (chunk_q),
            .carry_o (carry_q)
        );
    end

    assign out_valid     = g_stage[STAGES-1].valid_q;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = advance;
    assign bus.sum       = g_stage[STAGES-1].sum_acc;
    assign bus.cout      = g_stage[STAGES-1].carry_q;

`ifdef PIPE_ADDSUB_FLAGS_EN
    logic a_msb, b_msb, s_msb;

    // Z is qualified by out_valid so the flags read all-zero straight out of reset.
    always_comb begin
        a_msb     = g_stage[STAGES-1].msb_q[1];
        b_msb     = g_stage[STAGES-1].msb_q[0];
        s_msb     = bus.sum[WIDTH-1];
        bus.flags = {s_msb,
                     out_valid && (bus.sum == '0),
                     (a_msb == b_msb) && (s_msb != a_msb),
                     bus.cout};
    end
`endif

endmodule
